// File: rtl/test_monitor.sv
// test_monitor: end-of-test verdict engine placed beside the core.
// Watches either a PC trap (MODE 0) or a tohost store (MODE 1), decodes the
// status word into pass/fail/code, and forces a timeout verdict so every run
// finishes with exactly one sticky result.
module test_monitor #(
    parameter int unsigned     XLEN        = 32,
    parameter int unsigned     CNT_W       = 32,
    parameter int unsigned     MODE        = 0,
    parameter logic [XLEN-1:0] PASS_PC     = 'h44,
    parameter int unsigned     SETTLE      = 2,
    parameter logic [XLEN-1:0] TOHOST_ADDR = 'h1000,
    parameter int unsigned     TIMEOUT     = 5000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic [XLEN-1:0]  pc,
    input  logic [XLEN-1:0]  result,
    input  logic             wr_en,
    input  logic [XLEN-1:0]  wr_addr,
    input  logic [XLEN-1:0]  wr_data,
    output logic             done,
    output logic             pass,
    output logic             fail,
    output logic             timeout,
    output logic [XLEN-1:0]  code,
    output logic [CNT_W-1:0] cycles
);

    localparam int unsigned HOLD_W = 4;

    localparam logic [1:0] RUN  = 2'd0;
    localparam logic [1:0] HOLD = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]        state_q;
    logic [1:0]        state_d;
    logic [HOLD_W-1:0] hold_q;
    logic [HOLD_W-1:0] hold_d;
    logic [HOLD_W-1:0] hold_inc;
    logic [CNT_W-1:0]  cycles_d;
    logic              done_d;
    logic              pass_d;
    logic              fail_d;
    logic              timeout_d;
    logic [XLEN-1:0]   code_d;
    logic              sample;
    logic [XLEN-1:0]   word;
    logic              counting;
    logic              pc_hit;
    logic              store_hit;
    logic              last_cycle;

    // Qualifying events decoded once so the FSM below reads as the rules
    assign pc_hit     = (pc == PASS_PC);
    assign store_hit  = wr_en && (wr_addr == TOHOST_ADDR);
    assign counting   = (state_q == RUN) || (state_q == HOLD);
    assign last_cycle = (cycles == CNT_W'(TIMEOUT - 1));
    assign hold_inc   = hold_q + HOLD_W'(1);

    // State and output registers; everything is cleared asynchronously
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RUN;
            hold_q  <= '0;
            cycles  <= '0;
            done    <= 1'b0;
            pass    <= 1'b0;
            fail    <= 1'b0;
            timeout <= 1'b0;
            code    <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            cycles  <= cycles_d;
            done    <= done_d;
            pass    <= pass_d;
            fail    <= fail_d;
            timeout <= timeout_d;
            code    <= code_d;
        end
    end

    // Next-state, sampling and verdict decode; clear overrides everything
    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        cycles_d  = cycles;
        done_d    = done;
        pass_d    = pass;
        fail_d    = fail;
        timeout_d = timeout;
        code_d    = code;
        sample    = 1'b0;
        word      = '0;

        case (state_q)
            RUN: begin
                if (MODE == 0) begin
                    if (pc_hit) begin
                        if (SETTLE == 1) begin
                            sample = 1'b1;
                            word   = result;
                        end else begin
                            state_d = HOLD;
                            hold_d  = HOLD_W'(1);
                        end
                    end
                end else if (store_hit) begin
                    sample = 1'b1;
                    word   = wr_data;
                end
            end
            HOLD: begin
                if (pc_hit) begin
                    hold_d = hold_inc;
                    if (hold_inc == HOLD_W'(SETTLE)) begin
                        sample = 1'b1;
                        word   = result;
                    end
                end else begin
                    state_d = RUN;
                    hold_d  = '0;
                end
            end
            DONE: begin
                // absorbing: inputs ignored, counter frozen
            end
            default: begin
                state_d = RUN;
                hold_d  = '0;
            end
        endcase

        // Live states count every clock; a sample beats a same-cycle timeout
        if (counting) begin
            cycles_d = cycles + CNT_W'(1);
            if (sample) begin
                state_d = DONE;
                hold_d  = '0;
                done_d  = 1'b1;
                if (word == XLEN'(1)) begin
                    pass_d = 1'b1;
                    code_d = '0;
                end else begin
                    fail_d = 1'b1;
                    code_d = word >> 1;
                end
            end else if (last_cycle) begin
                state_d   = DONE;
                hold_d    = '0;
                done_d    = 1'b1;
                timeout_d = 1'b1;
            end
        end

        if (clear) begin
            state_d   = RUN;
            hold_d    = '0;
            cycles_d  = '0;
            done_d    = 1'b0;
            pass_d    = 1'b0;
            fail_d    = 1'b0;
            timeout_d = 1'b0;
            code_d    = '0;
        end
    end

endmodule

// File: tb/tb_test_monitor.sv
// tb_test_monitor: directed scenarios plus a randomized run against a
// behavioural model for three monitor configurations sharing one stimulus.
module tb_test_monitor;

    logic        clk;
    logic        rst;
    logic        clear;
    logic [31:0] pc;
    logic [31:0] result;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;

    logic [2:0]  done_v;
    logic [2:0]  pass_v;
    logic [2:0]  fail_v;
    logic [2:0]  to_v;
    logic [31:0] code_v [3];
    logic [31:0] cyc_v  [3];

    int n_vec;
    int n_err;

    // configurations: dut0 PC-trap SETTLE=2, dut1 tohost, dut2 PC-trap SETTLE=1
    int unsigned p_mode    [3] = '{0, 1, 0};
    int unsigned p_settle  [3] = '{2, 2, 1};
    int unsigned p_timeout [3] = '{200, 20, 50};

    // model state: verdict flags, code, counted clocks, consecutive trap streak
    logic        m_done [3];
    logic        m_pass [3];
    logic        m_fail [3];
    logic        m_to   [3];
    logic [31:0] m_code [3];
    int unsigned m_cyc  [3];
    int unsigned m_streak [3];

    test_monitor #(.XLEN(32), .CNT_W(32), .MODE(0), .PASS_PC(32'h44), .SETTLE(2),
                   .TOHOST_ADDR(32'h1000), .TIMEOUT(200)) dut0 (
        .clk(clk), .rst(rst), .clear(clear), .pc(pc), .result(result),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .done(done_v[0]), .pass(pass_v[0]), .fail(fail_v[0]), .timeout(to_v[0]),
        .code(code_v[0]), .cycles(cyc_v[0]));

    test_monitor #(.XLEN(32), .CNT_W(32), .MODE(1), .PASS_PC(32'h44), .SETTLE(2),
                   .TOHOST_ADDR(32'h1000), .TIMEOUT(20)) dut1 (
        .clk(clk), .rst(rst), .clear(clear), .pc(pc), .result(result),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .done(done_v[1]), .pass(pass_v[1]), .fail(fail_v[1]), .timeout(to_v[1]),
        .code(code_v[1]), .cycles(cyc_v[1]));

    test_monitor #(.XLEN(32), .CNT_W(32), .MODE(0), .PASS_PC(32'h44), .SETTLE(1),
                   .TOHOST_ADDR(32'h1000), .TIMEOUT(50)) dut2 (
        .clk(clk), .rst(rst), .clear(clear), .pc(pc), .result(result),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .done(done_v[2]), .pass(pass_v[2]), .fail(fail_v[2]), .timeout(to_v[2]),
        .code(code_v[2]), .cycles(cyc_v[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // observed tuple {done,pass,fail,timeout,code,cycles} of one instance
    function automatic logic [67:0] obs(input int d);
        return {done_v[d], pass_v[d], fail_v[d], to_v[d], code_v[d], cyc_v[d]};
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 3; d++) begin
            m_done[d] = 1'b0; m_pass[d] = 1'b0; m_fail[d] = 1'b0; m_to[d] = 1'b0;
            m_code[d] = '0; m_cyc[d] = 0; m_streak[d] = 0;
        end
    endtask

    // advance the model by one clock using the inputs currently applied
    task automatic model_step();
        logic        smp;
        logic [31:0] w;
        for (int d = 0; d < 3; d++) begin
            if (clear) begin
                m_done[d] = 1'b0; m_pass[d] = 1'b0; m_fail[d] = 1'b0; m_to[d] = 1'b0;
                m_code[d] = '0; m_cyc[d] = 0; m_streak[d] = 0;
            end else if (!m_done[d]) begin
                m_cyc[d] = m_cyc[d] + 1;
                smp = 1'b0;
                w   = '0;
                if (p_mode[d] == 0) begin
                    if (pc == 32'h44) begin
                        m_streak[d] = m_streak[d] + 1;
                        if (m_streak[d] >= p_settle[d]) begin
                            smp = 1'b1;
                            w   = result;
                        end
                    end else begin
                        m_streak[d] = 0;
                    end
                end else if (wr_en && wr_addr == 32'h1000) begin
                    smp = 1'b1;
                    w   = wr_data;
                end
                if (smp) begin
                    m_done[d] = 1'b1;
                    if (w == 32'd1) m_pass[d] = 1'b1;
                    else begin
                        m_fail[d] = 1'b1;
                        m_code[d] = w / 2;
                    end
                end else if (m_cyc[d] == p_timeout[d]) begin
                    m_done[d] = 1'b1;
                    m_to[d]   = 1'b1;
                end
            end
        end
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0; clear = 1'b0; pc = '0; result = '0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        model_reset();
        #2;
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1; clear = 1'b0; pc = 32'h44; result = 32'd1;
        wr_en = 1'b1; wr_addr = 32'h1000; wr_data = 32'd1;
        #2;
        rst = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) begin
            n_vec++;
            if (obs(d) !== 68'd0) begin
                n_err++;
                $display("FAIL reset_dut%0d: got %h want 0", d, obs(d));
            end
        end
        // held in reset across edges with qualifying stimulus
        @(posedge clk); #1;
        @(posedge clk); #1;
        for (int d = 0; d < 3; d++) begin
            n_vec++;
            if (obs(d) !== 68'd0) begin
                n_err++;
                $display("FAIL reset_hold_dut%0d: got %h want 0", d, obs(d));
            end
        end
    endtask

    task automatic test_mode0_pass();
        do_reset();
        result = 32'd1; pc = 32'h40;
        repeat (10) step();
        pc = 32'h44;
        step();
        n_vec++;
        if (done_v[0] !== 1'b0) begin
            n_err++;
            $display("FAIL m0_edge11_done: got %b want 0", done_v[0]);
        end
        step();
        n_vec++;
        if (obs(0) !== {4'b1100, 32'd0, 32'd12}) begin
            n_err++;
            $display("FAIL m0_pass: got %h want %h", obs(0), {4'b1100, 32'd0, 32'd12});
        end
        n_vec++;
        if (obs(2) !== {4'b1100, 32'd0, 32'd11}) begin
            n_err++;
            $display("FAIL m0_settle1_pass: got %h want %h", obs(2), {4'b1100, 32'd0, 32'd11});
        end
        pc = 32'h48; result = 32'h0B;
        repeat (3) step();
        n_vec++;
        if (obs(0) !== {4'b1100, 32'd0, 32'd12}) begin
            n_err++;
            $display("FAIL m0_done_frozen: got %h want %h", obs(0), {4'b1100, 32'd0, 32'd12});
        end
    endtask

    task automatic test_mode0_glitch_fail();
        do_reset();
        result = 32'h0B; pc = 32'h40;
        repeat (3) step();
        pc = 32'h44;
        step();
        pc = 32'h48;
        repeat (3) step();
        n_vec++;
        if (obs(0) !== {4'b0000, 32'd0, 32'd7}) begin
            n_err++;
            $display("FAIL m0_glitch: got %h want %h", obs(0), {4'b0000, 32'd0, 32'd7});
        end
        pc = 32'h44;
        repeat (2) step();
        n_vec++;
        if (obs(0) !== {4'b1010, 32'd5, 32'd9}) begin
            n_err++;
            $display("FAIL m0_fail: got %h want %h", obs(0), {4'b1010, 32'd5, 32'd9});
        end
    endtask

    task automatic test_mode1();
        do_reset();
        wr_en = 1'b1; wr_addr = 32'h1000; wr_data = 32'h07;
        step();
        wr_en = 1'b0;
        n_vec++;
        if (obs(1) !== {4'b1010, 32'd3, 32'd1}) begin
            n_err++;
            $display("FAIL m1_fail: got %h want %h", obs(1), {4'b1010, 32'd3, 32'd1});
        end
        do_reset();
        wr_en = 1'b1; wr_addr = 32'h1004; wr_data = 32'd1;
        step();
        wr_en = 1'b0;
        step();
        n_vec++;
        if (obs(1) !== {4'b0000, 32'd0, 32'd2}) begin
            n_err++;
            $display("FAIL m1_wrong_addr: got %h want %h", obs(1), {4'b0000, 32'd0, 32'd2});
        end
        wr_en = 1'b1; wr_addr = 32'h1000; wr_data = 32'd1;
        step();
        wr_en = 1'b0;
        n_vec++;
        if (obs(1) !== {4'b1100, 32'd0, 32'd3}) begin
            n_err++;
            $display("FAIL m1_pass: got %h want %h", obs(1), {4'b1100, 32'd0, 32'd3});
        end
        do_reset();
        wr_en = 1'b1; wr_addr = 32'h1000; wr_data = 32'd0;
        step();
        wr_en = 1'b0;
        n_vec++;
        if (obs(1) !== {4'b1010, 32'd0, 32'd1}) begin
            n_err++;
            $display("FAIL m1_zero_word: got %h want %h", obs(1), {4'b1010, 32'd0, 32'd1});
        end
        do_reset();
        wr_en = 1'b1; wr_addr = 32'h1000; wr_data = 32'hFFFF_FFFF;
        step();
        wr_en = 1'b0;
        n_vec++;
        if (obs(1) !== {4'b1010, 32'h7FFF_FFFF, 32'd1}) begin
            n_err++;
            $display("FAIL m1_logical_shift: got %h want %h", obs(1), {4'b1010, 32'h7FFF_FFFF, 32'd1});
        end
    endtask

    task automatic test_timeout();
        do_reset();
        repeat (19) step();
        n_vec++;
        if (obs(1) !== {4'b0000, 32'd0, 32'd19}) begin
            n_err++;
            $display("FAIL to_before: got %h want %h", obs(1), {4'b0000, 32'd0, 32'd19});
        end
        step();
        n_vec++;
        if (obs(1) !== {4'b1001, 32'd0, 32'd20}) begin
            n_err++;
            $display("FAIL to_fire: got %h want %h", obs(1), {4'b1001, 32'd0, 32'd20});
        end
        do_reset();
        repeat (19) step();
        wr_en = 1'b1; wr_addr = 32'h1000; wr_data = 32'd1;
        step();
        wr_en = 1'b0;
        n_vec++;
        if (obs(1) !== {4'b1100, 32'd0, 32'd20}) begin
            n_err++;
            $display("FAIL to_sample_wins: got %h want %h", obs(1), {4'b1100, 32'd0, 32'd20});
        end
    endtask

    task automatic test_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
        n_vec++;
        if (obs(1) !== 68'd0) begin
            n_err++;
            $display("FAIL clr_done: got %h want 0", obs(1));
        end
        step();
        n_vec++;
        if (obs(1) !== {4'b0000, 32'd0, 32'd1}) begin
            n_err++;
            $display("FAIL clr_recount: got %h want %h", obs(1), {4'b0000, 32'd0, 32'd1});
        end
        clear = 1'b1; wr_en = 1'b1; wr_addr = 32'h1000; wr_data = 32'd1;
        step();
        clear = 1'b0; wr_en = 1'b0;
        n_vec++;
        if (obs(1) !== 68'd0) begin
            n_err++;
            $display("FAIL clr_vs_store: got %h want 0", obs(1));
        end
        step();
        n_vec++;
        if (obs(1) !== {4'b0000, 32'd0, 32'd1}) begin
            n_err++;
            $display("FAIL clr_vs_store_after: got %h want %h", obs(1), {4'b0000, 32'd0, 32'd1});
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        pc = 32'h44; result = 32'd1;
        step();
        #2;
        rst = 1'b0;
        #1;
        n_vec++;
        if (obs(0) !== 68'd0) begin
            n_err++;
            $display("FAIL arst_hold: got %h want 0", obs(0));
        end
        #1;
        rst = 1'b1;
        model_reset();
        pc = 32'h40;
        step();
        n_vec++;
        if (obs(0) !== {4'b0000, 32'd0, 32'd1}) begin
            n_err++;
            $display("FAIL arst_resume: got %h want %h", obs(0), {4'b0000, 32'd0, 32'd1});
        end
        wr_en = 1'b1; wr_addr = 32'h1000; wr_data = 32'd1;
        step();
        wr_en = 1'b0;
        n_vec++;
        if (obs(1) !== {4'b1100, 32'd0, 32'd2}) begin
            n_err++;
            $display("FAIL arst_pre_done: got %h want %h", obs(1), {4'b1100, 32'd0, 32'd2});
        end
        #2;
        rst = 1'b0;
        #1;
        n_vec++;
        if (obs(1) !== 68'd0) begin
            n_err++;
            $display("FAIL arst_done: got %h want 0", obs(1));
        end
        #1;
        rst = 1'b1;
        model_reset();
        step();
        n_vec++;
        if (obs(1) !== {4'b0000, 32'd0, 32'd1}) begin
            n_err++;
            $display("FAIL arst_done_resume: got %h want %h", obs(1), {4'b0000, 32'd0, 32'd1});
        end
    endtask

    task automatic test_random();
        logic        quiet;
        logic [67:0] exp_t;
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            quiet = ((i / 100) % 3) == 2;
            if (quiet) begin
                pc = 32'h40 + 32'($urandom_range(0, 1) * 8);
                wr_en = 1'b0;
                clear = ($urandom_range(0, 299) == 0);
            end else begin
                case ($urandom_range(0, 9))
                    0, 1, 2, 3, 4: pc = 32'h44;
                    5, 6, 7:       pc = 32'h40;
                    default:       pc = $urandom;
                endcase
                wr_en = ($urandom_range(0, 7) == 0);
                clear = ($urandom_range(0, 39) == 0);
            end
            result  = ($urandom_range(0, 2) == 0) ? 32'd1 : 32'($urandom_range(0, 31));
            wr_addr = ($urandom_range(0, 3) == 0) ? 32'h1004 : 32'h1000;
            case ($urandom_range(0, 3))
                0:       wr_data = 32'd1;
                1:       wr_data = $urandom;
                default: wr_data = 32'($urandom_range(0, 31));
            endcase
            step();
            if ($urandom_range(0, 149) == 0) begin
                rst = 1'b0;
                #1;
                model_reset();
            end
            for (int d = 0; d < 3; d++) begin
                exp_t = {m_done[d], m_pass[d], m_fail[d], m_to[d], m_code[d], m_cyc[d]};
                n_vec++;
                if (obs(d) !== exp_t) begin
                    n_err++;
                    $display("FAIL rand_dut%0d iter %0d: got %h want %h", d, i, obs(d), exp_t);
                end
            end
            if (rst == 1'b0) begin
                #1;
                rst = 1'b1;
            end
        end
        clear = 1'b0;
        wr_en = 1'b0;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        model_reset();
        test_reset();
        test_mode0_pass();
        test_mode0_glitch_fail();
        test_mode1();
        test_timeout();
        test_clear();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/test_monitor.md
# test_monitor

Synthesizable end-of-test monitor for the RISC-V core, instantiated beside `Core` in simulation and FPGA builds. It replaces hard-coded bench checks with a parametrised verdict engine. Pass/fail detection runs in one of two modes:
- **PC-trap:** the PC sits at a fixed address and the result register is examined.
- **tohost:** the core writes a status word to a fixed address.

A timeout and a cycle counter make every run terminate with exactly one verdict.

## Interface
Parameters:
- `XLEN`, 32, datapath width of `pc`, `result`, `wr_addr`, `wr_data`, `code`.
- `CNT_W`, 32, width of the cycle counter.
- `MODE`, 0, verdict mode: 0 = PC-trap, 1 = tohost write.
- `PASS_PC`, 32'h44, trap address watched in MODE 0.
- `SETTLE`, 2, consecutive cycles `pc` must equal `PASS_PC` before sampling (range 1..15).
- `TOHOST_ADDR`, 32'h1000, store address watched in MODE 1.
- `TIMEOUT`, 5000, cycles in RUN/HOLD before a timeout verdict (≥2, < 2^CNT_W).

Ports:
- `clk`, in, 1, core clock.
- `rst`, in, 1, asynchronous, active-low reset.
- `clear`, in, 1, synchronous restart: back to RUN, counters zeroed.
- `pc`, in, XLEN, core program counter.
- `result`, in, XLEN, core register x3 (gp).
- `wr_en`, in, 1, data-memory store strobe.
- `wr_addr`, in, XLEN, store address.
- `wr_data`, in, XLEN, store data.
- `done`, out, 1, verdict reached; sticky.
- `pass`, out, 1, verdict is pass.
- `fail`, out, 1, verdict is fail.
- `timeout`, out, 1, verdict is timeout.
- `code`, out, XLEN, failing test number (status word >> 1); 0 otherwise.
- `cycles`, out, CNT_W, cycles spent in RUN/HOLD; frozen in DONE.

## Operation
- **States:** RUN, HOLD, DONE.
- **Reset** (`rst`=0, asynchronous):
  - state = RUN, `cycles` = 0, hold counter = 0.
  - All outputs 0.
- **RUN, MODE 0:** when `pc`==`PASS_PC`:
  - SETTLE=1: sample immediately.
  - SETTLE>1: go to HOLD with hold count 1.
- **HOLD:**
  - Each cycle `pc`==`PASS_PC` increments the hold count.
  - When the count reaches SETTLE, sample `result` that cycle.
  - Any cycle with `pc`≠`PASS_PC` returns to RUN with hold count 0.
- **RUN, MODE 1:** `wr_en`=1 with `wr_addr`==`TOHOST_ADDR` samples `wr_data` that cycle. HOLD is unused.
- **Sampled word S:**
  - S==1: `pass`.
  - S≠1: `fail`, with `code` = S>>1 (logical shift).
  - S==0 counts as fail with `code`=0.
- **Counting:** `cycles` increments by 1 on every clock spent in RUN or HOLD.
- **Timeout:** if `cycles`==TIMEOUT−1 and no sample occurs that clock, go to DONE with `timeout`=1.
- **Verdict vs. timeout:** a sample on the same clock as the timeout wins; `timeout` stays 0.
- **DONE:** absorbing until reset or `clear`.
  - `pc`/`wr_*` ignored.
  - `cycles` holds its last value.
  - Exactly one of `pass`/`fail`/`timeout` is 1.
- **`clear`:** priority over every transition, including a sample or timeout on the same clock.
  - Next state RUN; `cycles`, hold count and all outputs return to 0.
  - Stimulus on that clock is ignored.
- **Counter sizing:** `cycles` never wraps because TIMEOUT < 2^CNT_W. The hold counter is 4 bits.

## Timing
- **Outputs:** all registered. Verdict flags, `done`, `code` and the final `cycles` all appear 1 clock after the sampling edge.
- **MODE 0 latency:** `pc` first equals `PASS_PC` in cycle k; `done` rises at edge k+SETTLE.
- **MODE 1 latency:** a qualifying store in cycle k gives `done` at edge k+1.
- **Timeout:** `done`/`timeout` rise after exactly TIMEOUT counted clocks; `cycles` then reads TIMEOUT.
- **Reset mid-run:** asserting `rst` at any point, including the clock the verdict registers, forces all outputs to 0 without waiting for `clk`.
  - Counting resumes on the first edge after release.

## Test plan
- **MODE 0 pass:** SETTLE=2, PASS_PC=0x44, `result`=1; `pc` steps 0x40→0x44 (held) at cycle 10 → `done`=`pass`=1 at edge 12, `code`=0, `cycles`=12.
- **MODE 0 fail and glitch:**
  - `pc` hits 0x44 for 1 cycle then leaves → no verdict, state RUN.
  - Later `pc` stays at 0x44 with `result`=0x0B → `fail`=1, `code`=5.
- **MODE 1:**
  - Store 0x1000←0x07 → `fail`=1, `code`=3 one clock later.
  - Separate run: store 0x1004←1 → ignored.
  - Store 0x1000←1 → `pass`=1.
- **Timeout priority:**
  - TIMEOUT=20 with no trap → `timeout`=1, `cycles`=20.
  - Repeat with a qualifying store on the 20th counted clock → `pass`=1, `timeout`=0.
- **`clear`:**
  - `clear` in DONE → outputs 0, then `cycles` counts from 1.
  - `clear` coincident with a qualifying store → no verdict.
- **Async reset:** drop `rst` mid-HOLD and mid-DONE between edges → all outputs 0 immediately, before the next `clk` edge.
